operand_stage: RTL
==================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 and the register count at 32.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 in_valid_i  in  1  decoded instruction present; in_ready_o  out  1  stage can accept.
REQ-005 rs_i5, rt_i5  in  5 each  source register addresses.
REQ-006 imm_i32  in  32  extended immediate; use_imm_i  in  1  select imm_i32 as the B operand.
REQ-007 funct_i6  in  6  ALU function; alt_i  in  1  ALU alternate-op flag.
REQ-008 wb_en_i  in  1, wb_addr_i5  in  5, wb_data_i32  in  32  register writeback port.
REQ-009 flush_i  in  1  discard the held operand bundle.
REQ-010 out_valid_o  out  1, out_ready_i  in  1  handshake toward the ALU.
REQ-011 a_o32, b_o32  out  32  ALU operands; funct_o6  out  6, alt_o  out  1  registered copies to the ALU.

Function
REQ-012 The block SHALL hold a 32x32 register file; register 0 reads as 0 and writes to it are ignored.
REQ-013 A write SHALL occur on the rising edge when wb_en_i=1 and wb_addr_i5!=0; writeback is independent of the handshake and of stall.
REQ-014 in_ready_o SHALL equal (!out_valid_o || out_ready_i) && !flush_i, combinationally.
REQ-015 Accept = in_valid_i && in_ready_o; on accept, the output register SHALL load a_o32=R[rs_i5], b_o32=(use_imm_i ? imm_i32 : R[rt_i5]), funct_o6, alt_o, and set out_valid_o=1 (latency 1 cycle).
REQ-016 When out_valid_o && out_ready_i && !accept, out_valid_o SHALL clear on the next edge.
REQ-017 Simultaneous consume and accept SHALL load the new bundle with out_valid_o staying 1 (back-to-back, no bubble).
REQ-018 While out_valid_o && !out_ready_i, all outputs SHALL hold stable; operands SHALL NOT be re-read even if a writeback changes the source register.
REQ-019 flush_i=1 SHALL clear out_valid_o on the next edge and block accept that cycle; flush has priority over accept and consume.
REQ-020 When out_valid_o=0, data outputs SHALL retain their last values (don't-care to the consumer).
REQ-021 Reads of register 0 SHALL return 0 even when a writeback to address 0 occurs in the same cycle.

Reset
REQ-022 rst_i=1 SHALL immediately clear all 32 registers, out_valid_o, a_o32, b_o32, funct_o6 and alt_o to 0, independent of clk_i.
REQ-023 Reset mid-operation SHALL discard any held bundle; a writeback coincident with reset SHALL be lost.
REQ-024 in_ready_o SHALL be 1 during and after reset (out_valid_o=0, flush_i=0).

Configuration
REQ-025 With REGFILE_BYPASS_EN defined, a read in an accept cycle whose address equals a same-cycle writeback address (non-zero, wb_en_i=1) SHALL return wb_data_i32.
REQ-026 Without REGFILE_BYPASS_EN, that read SHALL return the register value before the write; the write still completes.

Verification
REQ-027 Reset, write R5=0x0000_0007 and R6=0x0000_0003, accept rs=5, rt=6, use_imm=0, funct=ADD -> next cycle out_valid_o=1, a_o32=0x7, b_o32=0x3, funct_o6=ADD.
REQ-028 Accept rs=5, use_imm=1, imm=0xFFFF_FFF0 -> b_o32=0xFFFF_FFF0; write R0=0x1234 then read rs=0 -> a_o32=0.
REQ-029 Hold out_ready_i=0 for 3 cycles with in_valid_i=1 and a writeback to R5=0x99 -> in_ready_o=0, outputs unchanged (a_o32=0x7); release -> next bundle reads 0x99, no bubble with out_ready_i held 1.
REQ-030 Same-cycle wb R7=0xAAAA_5555 and accept rs=7 -> a_o32=0xAAAA_5555 with REGFILE_BYPASS_EN, previous R7 value without it.
REQ-031 Assert flush_i with out_valid_o=1 and in_valid_i=1 -> in_ready_o=0, out_valid_o=0 next cycle, no bundle accepted.
REQ-032 Assert rst_i between edges while out_valid_o=1 -> out_valid_o=0 and R5 reads 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/operand_stage.sv
// Operand fetch stage: 32x32 register file with a one-entry valid/ready output register toward the ALU.
// Optional REGFILE_BYPASS_EN forwards a same-cycle writeback to the read ports.
module operand_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  rs_i5,
  input  logic [4:0]  rt_i5,
  input  logic [31:0] imm_i32,
  input  logic        use_imm_i,
  input  logic [5:0]  funct_i6,
  input  logic        alt_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_addr_i5,
  input  logic [31:0] wb_data_i32,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] a_o32,
  output logic [31:0] b_o32,
  output logic [5:0]  funct_o6,
  output logic        alt_o
);

  logic [31:0] regs_r [32];
  logic [31:0] rd_a_s;
  logic [31:0] rd_b_s;
  logic [31:0] b_sel_s;
  logic        accept_s;
  logic        out_valid_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [5:0]  funct_r;
  logic        alt_r;

  // Handshake: stage accepts when the output slot is free or draining, never while flushing.
  always_comb begin
    in_ready_o = (!out_valid_r || out_ready_i) && !flush_i;
    accept_s   = in_valid_i && in_ready_o;
  end

  // Register file read ports; address 0 is hard-wired to zero.
  always_comb begin
    rd_a_s  = 32'h0000_0000;
    rd_b_s  = 32'h0000_0000;
    if (rs_i5 != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_en_i && (wb_addr_i5 == rs_i5)) begin
        rd_a_s = wb_data_i32;
      end else begin
        rd_a_s = regs_r[rs_i5];
      end
`else
      rd_a_s = regs_r[rs_i5];
`endif
    end else begin
      rd_a_s = 32'h0000_0000;
    end
    if (rt_i5 != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
      if (wb_en_i && (wb_addr_i5 == rt_i5)) begin
        rd_b_s = wb_data_i32;
      end else begin
        rd_b_s = regs_r[rt_i5];
      end
`else
      rd_b_s = regs_r[rt_i5];
`endif
    end else begin
      rd_b_s = 32'h0000_0000;
    end
    if (use_imm_i) begin
      b_sel_s = imm_i32;
    end else begin
      b_sel_s = rd_b_s;
    end
  end

  // Register file write port; runs regardless of stall or handshake state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (wb_en_i && (wb_addr_i5 != 5'd0)) begin
      regs_r[wb_addr_i5] <= wb_data_i32;
    end else begin
      regs_r[wb_addr_i5] <= regs_r[wb_addr_i5];
    end
  end

  // Output bundle register; flush beats accept, accept beats a plain consume.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_r <= 1'b0;
      a_r         <= 32'h0000_0000;
      b_r         <= 32'h0000_0000;
      funct_r     <= 6'd0;
      alt_r       <= 1'b0;
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      a_r         <= rd_a_s;
      b_r         <= b_sel_s;
      funct_r     <= funct_i6;
      alt_r       <= alt_i;
    end else if (out_ready_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid_o = out_valid_r;
  assign a_o32       = a_r;
  assign b_o32       = b_r;
  assign funct_o6    = funct_r;
  assign alt_o       = alt_r;

endmodule
